reg_file_2r1w: RTL and testbench

//  Architectural register file for the datapath: 32 entries x 32 bits, two asynchronous

---
 rtl/regfile_pkg.sv | 11 +
 rtl/reg_wr_decoder.sv | 19 +
 rtl/reg_file_2r1w.sv | 69 ++++++
 tb/tb_reg_file_2r1w.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file geometry and types; imported by the register file, ALU and decode stages.
// Combinational helpers only, no state.
package regfile_pkg;
   localparam int DATA_W   = 32;
   localparam int NUM_REGS = 32;
   localparam int ADDR_W   = 5;
   localparam int ZERO_REG = 31;

   typedef logic [ADDR_W-1:0] reg_addr_t;
   typedef logic [DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/reg_wr_decoder.sv
// Write-address decoder: one-hot entry enable, gated by wr_en, zero-register bit held low.
// Purely combinational, 0-cycle latency; no backpressure.
module reg_wr_decoder
   import regfile_pkg::*;
(
   input  logic                wr_en,
   input  reg_addr_t           wr_addr,
   output logic [NUM_REGS-1:0] wr_sel
);

   always_comb begin
      wr_sel = '0;
      if (wr_en) begin
         wr_sel[wr_addr] = 1'b1;
      end
      wr_sel[ZERO_REG] = 1'b0;
   end

endmodule

// File: rtl/reg_file_2r1w.sv
// 32x32 register file, two async read ports and one sync write port (1-cycle write, 0-cycle read).
// Always accepts a write and a read on each port every cycle; no backpressure.
module reg_file_2r1w
   import regfile_pkg::*;
#(
   parameter bit BYPASS = 1'b1
)
(
   input  logic      clk,
   input  logic      reset_n,
   input  logic      wr_en,
   input  reg_addr_t wr_addr,
   input  reg_data_t wr_data,
   input  reg_addr_t rd_addr1,
   input  reg_addr_t rd_addr2,
   output reg_data_t rd_data1,
   output reg_data_t rd_data2
);

   if (NUM_REGS != (1 << ADDR_W)) begin : g_bad_cfg
      $error("reg_file_2r1w: NUM_REGS must equal 2**ADDR_W");
   end

   reg_data_t           regs [NUM_REGS];
   logic [NUM_REGS-1:0] wr_sel;
   logic                byp_ok;

   reg_wr_decoder u_dec (
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_sel  (wr_sel)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_sel[i]) begin
               regs[i] <= wr_data;
            end
         end
      end
   end

   // Bypass is suppressed during reset so held-reset reads stay 0 even with wr_en high.
   assign byp_ok = BYPASS && wr_en && reset_n;

   always_comb begin
      rd_data1 = regs[rd_addr1];
      if (byp_ok && (wr_addr == rd_addr1)) begin
         rd_data1 = wr_data;
      end
      if (rd_addr1 == reg_addr_t'(ZERO_REG)) begin
         rd_data1 = '0;
      end

      rd_data2 = regs[rd_addr2];
      if (byp_ok && (wr_addr == rd_addr2)) begin
         rd_data2 = wr_data;
      end
      if (rd_addr2 == reg_addr_t'(ZERO_REG)) begin
         rd_data2 = '0;
      end
   end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Scoreboarded bench for reg_file_2r1w: one instance with bypass, one without, same stimulus.
// Driver pushes expected read data per cycle; a negedge monitor pops and compares.
module tb_reg_file_2r1w;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [4:0]  rd_addr1;
   logic [4:0]  rd_addr2;
   logic [31:0] rd_data1_b, rd_data2_b;
   logic [31:0] rd_data1_n, rd_data2_n;

   always #5 clk = ~clk;

   reg_file_2r1w #(.BYPASS(1'b1)) dut_byp (
      .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(rd_data1_b), .rd_data2(rd_data2_b)
   );

   reg_file_2r1w #(.BYPASS(1'b0)) dut_nob (
      .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(rd_data1_n), .rd_data2(rd_data2_n)
   );

   // Reference model: plain array of architectural register contents.
   logic [31:0] model [32];

   typedef struct {
      string       name;
      logic [31:0] e1_b;
      logic [31:0] e2_b;
      logic [31:0] e1_n;
      logic [31:0] e2_n;
   } sb_item_t;

   sb_item_t sbq [$];
   int n_checks = 0;
   int n_errors = 0;

   function automatic logic [31:0] exp_rd(input bit byp, input logic rst_n, input logic we,
                                          input logic [4:0] wa, input logic [31:0] wd,
                                          input logic [4:0] ra);
      if (!rst_n || ra == 5'd31) return 32'h0;
      if (byp && we && wa == ra) return wd;
      return model[ra];
   endfunction

   task automatic push(input string nm);
      sb_item_t it;
      it.name = nm;
      it.e1_b = exp_rd(1'b1, reset_n, wr_en, wr_addr, wr_data, rd_addr1);
      it.e2_b = exp_rd(1'b1, reset_n, wr_en, wr_addr, wr_data, rd_addr2);
      it.e1_n = exp_rd(1'b0, reset_n, wr_en, wr_addr, wr_data, rd_addr1);
      it.e2_n = exp_rd(1'b0, reset_n, wr_en, wr_addr, wr_data, rd_addr2);
      sbq.push_back(it);
   endtask

   task automatic check(input string nm, input string port, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s %s: got %h expected %h (t=%0t)", nm, port, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (sbq.size() > 0) begin
         sb_item_t it;
         it = sbq.pop_front();
         check(it.name, "byp.rd1", rd_data1_b, it.e1_b);
         check(it.name, "byp.rd2", rd_data2_b, it.e2_b);
         check(it.name, "nob.rd1", rd_data1_n, it.e1_n);
         check(it.name, "nob.rd2", rd_data2_n, it.e2_n);
      end
   end

   // One cycle of stimulus; called just after a rising edge.
   task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] ra1, input logic [4:0] ra2, input string nm);
      wr_en    = we;
      wr_addr  = wa;
      wr_data  = wd;
      rd_addr1 = ra1;
      rd_addr2 = ra2;
      push(nm);
      @(posedge clk);
      if (reset_n && we && wa != 5'd31) model[wa] = wd;
      #1;
   endtask

   initial begin
      logic [4:0] wa, ra1, ra2;
      reset_n  = 1'b0;
      wr_en    = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
      rd_addr1 = '0;
      rd_addr2 = '0;
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      @(posedge clk);
      #1;

      // Reset state, including a write attempted while reset is held.
      drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd3, "rst_state");
      drive(1'b1, 5'd7, 32'h1234_5678, 5'd7, 5'd7, "rst_wr_held");
      wr_en   = 1'b0;
      reset_n = 1'b1;
      drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd30, "post_rst");

      // Asynchronous reset mid-cycle after loading r3.
      drive(1'b1, 5'd3, 32'hDEAD_BEEF, 5'd0, 5'd1, "ld_r3");
      drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd3, "rd_r3");
      wr_en    = 1'b0;
      rd_addr1 = 5'd3;
      rd_addr2 = 5'd3;
      #1;
      reset_n = 1'b0;
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      push("rst_async");
      @(posedge clk);
      #1;
      for (int i = 0; i < 32; i++) drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), "rst_sweep");
      reset_n = 1'b1;
      drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd5, "rst_release");

      // Operand writes, adder result writeback.
      drive(1'b1, 5'd0, 32'h5, 5'd0, 5'd1, "wr_r0");
      drive(1'b1, 5'd1, 32'h7, 5'd0, 5'd1, "wr_r1");
      drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd1, "rd_r0_r1");
      drive(1'b1, 5'd2, model[0] + model[1], 5'd0, 5'd1, "wr_sum");
      drive(1'b0, 5'd0, 32'h0, 5'd2, 5'd2, "rd_sum");

      // Zero register.
      drive(1'b1, 5'd31, 32'hFFFF_FFFF, 5'd31, 5'd31, "zero_wr");
      drive(1'b0, 5'd0, 32'h0, 5'd31, 5'd31, "zero_rd");

      // Bypass versus old value.
      drive(1'b1, 5'd4, 32'h1111_1111, 5'd4, 5'd0, "byp_ld");
      drive(1'b1, 5'd4, 32'h2222_2222, 5'd4, 5'd4, "byp_same");
      drive(1'b0, 5'd0, 32'h0, 5'd4, 5'd4, "byp_after");

      // Disabled write is ignored.
      for (int i = 0; i < 3; i++) drive(1'b0, 5'd6, 32'hABCD_ABCD, 5'd6, 5'd6, "wr_dis");
      drive(1'b0, 5'd0, 32'h0, 5'd6, 5'd6, "wr_dis_rd");

      // Walking ones: no aliasing between entries.
      for (int i = 0; i < 31; i++) drive(1'b1, 5'(i), 32'h1 << i, 5'd31, 5'd31, "walk_wr");
      for (int i = 0; i < 31; i++) drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(30 - i), "walk_rd");

      // Random traffic with frequent read/write address collisions.
      for (int n = 0; n < 400; n++) begin
         wa  = 5'($urandom_range(0, 31));
         ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
         ra2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
         drive(1'($urandom_range(0, 1)), wa, $urandom, ra1, ra2, "rand");
      end

      for (int k = 0; k < 10 && sbq.size() > 0; k++) @(posedge clk);
      if (sbq.size() > 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain: %0d items left, expected 0", sbq.size());
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
